// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow input (sig_in) in fast clk cycles,
// with a sticky loss-of-signal timeout. Results update with a one-cycle valid pulse.
module clk_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TO_CNT = WIDTH'(TIMEOUT);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hlat_q, hlat_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             rise, fall, cnt_expired;

  assign rise        = s2_q & ~s3_q;
  assign fall        = ~s2_q & s3_q;
  assign cnt_expired = (cnt_q == TO_CNT);

  // Synchronizer runs regardless of en so edges are valid immediately on re-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = MEASURE;
        MEASURE: if (!rise && cnt_expired) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    hlat_d    = hlat_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    if (!en) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d  = WIDTH'(1);
            hlat_d = '0;
          end
        end
        MEASURE: begin
          cnt_d = cnt_q + WIDTH'(1);
          if (fall) hlat_d = cnt_q;
          // A rise on the expiry cycle is a live edge, so it beats the timeout.
          if (rise) begin
            period_d  = cnt_q;
            high_d    = hlat_q;
            valid_d   = 1'b1;
            locked_d  = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = WIDTH'(1);
            hlat_d    = '0;
          end else if (cnt_expired) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = '0;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      hlat_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hlat_q    <= hlat_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: directed waveforms push expected results into a
// queue; a monitor pops and compares on every valid pulse.
module tb_clk_period_meter;
  localparam int W  = 32;
  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         sig_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         locked;
  logic         timeout;

  int checks = 0;
  int passes = 0;
  int n_push = 0;
  int n_valid = 0;
  logic prev_valid = 1'b0;
  logic [W-1:0] exp_p_q[$];
  logic [W-1:0] exp_h_q[$];

  always #5 clk = ~clk;

  clk_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .valid(valid), .locked(locked), .timeout(timeout)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic expect_meas(input logic [W-1:0] p, input logic [W-1:0] h);
    exp_p_q.push_back(p);
    exp_h_q.push_back(h);
    n_push++;
  endtask

  // One input cycle: h cycles high then l low. The rise of this cycle reports
  // the previous cycle, so the expectation (if any) is pushed before the rise.
  task automatic wave(input int h, input int l, input bit exp_v,
                      input logic [W-1:0] ep, input logic [W-1:0] eh, input bit lat);
    if (exp_v) expect_meas(ep, eh);
    sig_in = 1'b1;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      if (lat && i == 1) chk_bit("latency_before", valid, 1'b0);
      if (lat && i == 2) chk_bit("latency_at", valid, 1'b1);
    end
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, period, '0);
    check({tag, "_high_time"}, high_time, '0);
    chk_bit({tag, "_valid"}, valid, 1'b0);
    chk_bit({tag, "_locked"}, locked, 1'b0);
    chk_bit({tag, "_timeout"}, timeout, 1'b0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      chk_bit("valid_one_cycle", prev_valid, 1'b0);
      if (exp_p_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: valid=1 with nothing expected, period=%0d high_time=%0d",
                 period, high_time);
      end else begin
        check("period", period, exp_p_q.pop_front());
        check("high_time", high_time, exp_h_q.pop_front());
        chk_bit("locked_on_valid", locked, 1'b1);
      end
    end
    prev_valid = valid;
  end

  always @(posedge valid) begin
    if (rst) chk_bit("valid_during_reset", valid, 1'b0);
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    sig_in = 1'b0;
    repeat (6) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    check_all_zero("reset");
    sig_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Divider-style square wave, H=5
    wave(5, 5, 1'b0, 0, 0, 1'b0);
    wave(5, 5, 1'b1, 10, 5, 1'b1);
    wave(5, 5, 1'b1, 10, 5, 1'b0);
    wave(5, 5, 1'b1, 10, 5, 1'b0);

    // Asymmetric duty, then a fast 2/2 wave
    wave(3, 7, 1'b1, 10, 5, 1'b0);
    wave(3, 7, 1'b1, 10, 3, 1'b0);
    wave(3, 7, 1'b1, 10, 3, 1'b0);
    wave(2, 2, 1'b1, 10, 3, 1'b0);
    wave(2, 2, 1'b1, 4, 2, 1'b0);
    wave(5, 5, 1'b1, 4, 2, 1'b0);
    wave(5, 5, 1'b1, 10, 5, 1'b0);

    // Loss of signal: timeout lands 50 cycles after the last rise cycle
    repeat (42) @(negedge clk);
    chk_bit("timeout_early", timeout, 1'b0);
    chk_bit("locked_before_to", locked, 1'b1);
    @(negedge clk);
    chk_bit("timeout_set", timeout, 1'b1);
    chk_bit("locked_after_to", locked, 1'b0);
    check("period_hold_to", period, 10);
    check("high_hold_to", high_time, 5);
    repeat (5) @(negedge clk);
    wave(5, 5, 1'b0, 0, 0, 1'b0);
    chk_bit("timeout_sticky", timeout, 1'b1);
    wave(5, 5, 1'b1, 10, 5, 1'b0);
    chk_bit("timeout_cleared", timeout, 1'b0);
    chk_bit("relocked_after_to", locked, 1'b1);

    // Enable drop mid-period for 20 cycles
    expect_meas(10, 5);
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    sig_in = 1'b1; repeat (5) @(negedge clk);
    sig_in = 1'b0; repeat (5) @(negedge clk);
    sig_in = 1'b1; repeat (5) @(negedge clk);
    sig_in = 1'b0; repeat (2) @(negedge clk);
    chk_bit("locked_en_off", locked, 1'b0);
    check("period_hold_en", period, 10);
    check("high_hold_en", high_time, 5);
    chk_bit("timeout_hold_en", timeout, 1'b0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    wave(5, 5, 1'b0, 0, 0, 1'b0);
    wave(3, 7, 1'b1, 10, 5, 1'b0);
    wave(5, 5, 1'b1, 10, 3, 1'b0);
    chk_bit("relocked_after_en", locked, 1'b1);

    // Asynchronous reset between rises, away from any clock edge
    expect_meas(10, 5);
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    sig_in = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    repeat (4) begin
      @(negedge clk);
      sig_in = ~sig_in;
    end
    sig_in = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    wave(5, 5, 1'b0, 0, 0, 1'b0);
    wave(5, 5, 1'b1, 10, 5, 1'b0);
    wave(5, 5, 1'b1, 10, 5, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_expectations", exp_p_q.size(), 0);
    check("valid_count", n_valid, n_push);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
